// File: rtl/rast_pkg.sv
// Shared types for the rasteriser tile path: shadow-pipeline tag, scheduler state, fp18 width.
package rast_pkg;

  localparam int FP18_W = 18;

  typedef struct packed {
    logic        valid;
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
  } tile_tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/tag_pipe.sv
// Fixed-depth delay line of tile tags that mirrors the evaluator's datapath pipeline.
module tag_pipe
  import rast_pkg::*;
#(
  parameter int DEPTH = 24
) (
  input  logic      clk,
  input  logic      rst,
  input  tile_tag_t d,
  output tile_tag_t q,
  output logic      any_valid
);

  tile_tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i].valid;
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/plane_tile_sched.sv
// Walks a triangle bbox in SIZE x SIZE tiles row-major, feeds the plane evaluator under
// downstream credit control, and tags each tile so out_* lines up with the evaluator's z.
module plane_tile_sched
  import rast_pkg::*;
#(
  parameter int SIZE      = 2,
  parameter int LATENCY   = 24,
  parameter int COEF_HOLD = 9,
  parameter int CREDITS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tri_valid,
  output logic              tri_ready,
  input  logic [15:0]       tri_x0,
  input  logic [15:0]       tri_y0,
  input  logic [15:0]       tri_x1,
  input  logic [15:0]       tri_y1,
  input  logic [FP18_W-1:0] tri_dzdx,
  input  logic [FP18_W-1:0] tri_dzdy,
  input  logic [FP18_W-1:0] tri_c,
  output logic [15:0]       pe_x,
  output logic [15:0]       pe_y,
  output logic [FP18_W-1:0] pe_dzdx,
  output logic [FP18_W-1:0] pe_dzdy,
  output logic [FP18_W-1:0] pe_c,
  input  logic              credit_return,
  output logic              out_valid,
  output logic [15:0]       out_x,
  output logic [15:0]       out_y,
  output logic              out_last,
  output logic              busy
);

  localparam int          CW         = $clog2(CREDITS + 1);
  localparam int          HW         = (COEF_HOLD > 1) ? $clog2(COEF_HOLD) : 1;
  localparam logic [15:0] ALIGN_MASK = ~16'(SIZE - 1);
  localparam logic [16:0] STEP       = 17'(SIZE);

  // tri_valid/tri_ready: a setup transfers on any rising clk edge where both are high;
  // the setup fields must be stable while tri_valid is high and tri_ready is low.
  sched_state_t  state, state_nxt;
  logic [15:0]   cur_x, cur_y, ax0, x1_q, y1_q;
  logic [CW-1:0] credits;
  logic [HW-1:0] hold_cnt;
  logic          accept, empty_bbox, issue, col_end, row_end, last_tile, hold_done;
  logic          tags_busy;
  tile_tag_t     tag_q, tag_out;

  assign accept     = tri_valid && (state == IDLE);
  assign empty_bbox = (tri_x0 > tri_x1) || (tri_y0 > tri_y1);
  assign issue      = (state == ISSUE) && (credits != '0);
  // 17-bit compares so a tile at 0xFFFE does not wrap past the bbox edge
  assign col_end    = ({1'b0, cur_x} + STEP) > {1'b0, x1_q};
  assign row_end    = ({1'b0, cur_y} + STEP) > {1'b0, y1_q};
  assign last_tile  = col_end && row_end;
  assign hold_done  = (hold_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !empty_bbox) state_nxt = ISSUE;
      ISSUE:   if (issue && last_tile)    state_nxt = DRAIN;
      DRAIN:   if (hold_done)             state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tri_ready = (state == IDLE);
    busy      = (state != IDLE) || tag_q.valid || tags_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x    <= '0;
      cur_y    <= '0;
      ax0      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      pe_x     <= '0;
      pe_y     <= '0;
      pe_dzdx  <= '0;
      pe_dzdy  <= '0;
      pe_c     <= '0;
      hold_cnt <= '0;
      tag_q    <= '0;
    end else begin
      tag_q <= '0;
      if (accept) begin
        pe_dzdx <= tri_dzdx;
        pe_dzdy <= tri_dzdy;
        pe_c    <= tri_c;
        cur_x   <= tri_x0 & ALIGN_MASK;
        cur_y   <= tri_y0 & ALIGN_MASK;
        ax0     <= tri_x0 & ALIGN_MASK;
        x1_q    <= tri_x1;
        y1_q    <= tri_y1;
      end
      if (issue) begin
        pe_x        <= cur_x;
        pe_y        <= cur_y;
        tag_q.valid <= 1'b1;
        tag_q.x     <= cur_x;
        tag_q.y     <= cur_y;
        tag_q.last  <= last_tile;
        if (col_end) begin
          cur_x <= ax0;
          cur_y <= cur_y + 16'(SIZE);
        end else begin
          cur_x <= cur_x + 16'(SIZE);
        end
      end
      // coefficients must survive the evaluator's y-path delay after the final tile
      if (issue && last_tile)                hold_cnt <= HW'(COEF_HOLD - 1);
      else if (state == DRAIN && !hold_done) hold_cnt <= hold_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                     credits <= CW'(CREDITS);
    else if (issue && !credit_return)                            credits <= credits - 1'b1;
    else if (credit_return && !issue && credits != CW'(CREDITS)) credits <= credits + 1'b1;
  end

  credit_overflow: assert property (@(posedge clk) disable iff (rst)
    !(credit_return && !issue && credits == CW'(CREDITS)));

  tag_pipe #(.DEPTH(LATENCY)) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .d         (tag_q),
    .q         (tag_out),
    .any_valid (tags_busy)
  );

  assign out_valid = tag_out.valid;
  assign out_x     = tag_out.x;
  assign out_y     = tag_out.y;
  assign out_last  = tag_out.last;

endmodule
